// File: rtl/generic_sram_port_arbiter.sv
// Two-port valid/ready arbiter and sequencer for one single-port SRAM.
// Round-robin by default; SRAM_ARB_FIXED_PRIORITY_EN gives port 0 strict priority.
//
// Ports:
//   CLK, RSTN                      clock, async active-low reset
//   req_valid/ready/write[1:0]     per-port request handshake and type
//   req_addr0/1, req_data0/1,
//   req_mask0/1                    per-port request payload
//   rsp_valid[1:0], rsp_data0/1    registered read responses
//   sram_ceb/web/a/d/m, sram_q     SRAM macro bus (enables active high)
module generic_sram_port_arbiter #(
   parameter  int WIDTH         = 128,
   parameter  int NUM_ROWS      = 4096,
   localparam int ADDRESS_WIDTH = $clog2(NUM_ROWS)
) (
   input  logic                     CLK,
   input  logic                     RSTN,
   input  logic [1:0]               req_valid,
   output logic [1:0]               req_ready,
   input  logic [1:0]               req_write,
   input  logic [ADDRESS_WIDTH-1:0] req_addr0,
   input  logic [ADDRESS_WIDTH-1:0] req_addr1,
   input  logic [WIDTH-1:0]         req_data0,
   input  logic [WIDTH-1:0]         req_data1,
   input  logic [WIDTH-1:0]         req_mask0,
   input  logic [WIDTH-1:0]         req_mask1,
   output logic [1:0]               rsp_valid,
   output logic [WIDTH-1:0]         rsp_data0,
   output logic [WIDTH-1:0]         rsp_data1,
   output logic                     sram_ceb,
   output logic                     sram_web,
   output logic [ADDRESS_WIDTH-1:0] sram_a,
   output logic [WIDTH-1:0]         sram_d,
   output logic [WIDTH-1:0]         sram_m,
   input  logic [WIDTH-1:0]         sram_q
);

   logic [1:0]       gnt;
   logic             sel;
   logic             wr;
   logic             s1_v_d, s1_v_q;
   logic             s1_id_d, s1_id_q;
   logic [1:0]       rsp_valid_d, rsp_valid_q;
   logic [WIDTH-1:0] rsp_data0_d, rsp_data0_q;
   logic [WIDTH-1:0] rsp_data1_d, rsp_data1_q;

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
   always_comb begin
      gnt = 2'b00;
      if (RSTN) begin
         if (req_valid[0])      gnt = 2'b01;
         else if (req_valid[1]) gnt = 2'b10;
      end
   end
`else
   logic prio_d, prio_q;

   // Grants are masked while reset is asserted.
   always_comb begin
      gnt = 2'b00;
      if (RSTN) begin
         unique case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // The pointer moves to the port that just lost its turn.
   always_comb begin
      prio_d = prio_q;
      if (gnt[0]) prio_d = 1'b1;
      if (gnt[1]) prio_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) prio_q <= 1'b0;
      else       prio_q <= prio_d;
   end
`endif

   assign req_ready = gnt;
   assign sel       = gnt[1];
   assign wr        = sel ? req_write[1] : req_write[0];

   always_comb begin
      sram_ceb = 1'b0;
      sram_web = 1'b0;
      sram_a   = '0;
      sram_d   = '0;
      sram_m   = '0;
      if (|gnt) begin
         sram_ceb = 1'b1;
         sram_web = wr;
         sram_a   = sel ? req_addr1 : req_addr0;
         if (wr) begin
            sram_d = sel ? req_data1 : req_data0;
            sram_m = sel ? req_mask1 : req_mask0;
         end
      end
   end

   // Stage 1 tracks the read the SRAM is servicing; stage 2 is the
   // response register that captures its output one cycle later.
   always_comb begin
      s1_v_d      = sram_ceb & ~sram_web;
      s1_id_d     = sel;
      rsp_valid_d = 2'b00;
      rsp_data0_d = rsp_data0_q;
      rsp_data1_d = rsp_data1_q;
      if (s1_v_q) begin
         rsp_valid_d[s1_id_q] = 1'b1;
         if (s1_id_q) rsp_data1_d = sram_q;
         else         rsp_data0_d = sram_q;
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         s1_v_q      <= 1'b0;
         s1_id_q     <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_data0_q <= '0;
         rsp_data1_q <= '0;
      end else begin
         s1_v_q      <= s1_v_d;
         s1_id_q     <= s1_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data0_q <= rsp_data0_d;
         rsp_data1_q <= rsp_data1_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data0 = rsp_data0_q;
   assign rsp_data1 = rsp_data1_q;

endmodule

// File: tb/tb_generic_sram_port_arbiter.sv
// Directed bench for generic_sram_port_arbiter with a behavioural SRAM.
// Honours SRAM_ARB_FIXED_PRIORITY_EN for the expected grant pattern.
module tb_generic_sram_port_arbiter;

   localparam int W  = 128;
   localparam int AW = 12;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic [1:0]    req_valid, req_ready, req_write, rsp_valid;
   logic [AW-1:0] req_addr0, req_addr1, sram_a;
   logic [W-1:0]  req_data0, req_data1, req_mask0, req_mask1;
   logic [W-1:0]  rsp_data0, rsp_data1, sram_d, sram_m, sram_q;
   logic          sram_ceb, sram_web;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 CLK = ~CLK;

   generic_sram_port_arbiter #(.WIDTH(W), .NUM_ROWS(4096)) dut (
      .CLK(CLK), .RSTN(RSTN),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write),
      .req_addr0(req_addr0), .req_addr1(req_addr1),
      .req_data0(req_data0), .req_data1(req_data1),
      .req_mask0(req_mask0), .req_mask1(req_mask1),
      .rsp_valid(rsp_valid),
      .rsp_data0(rsp_data0), .rsp_data1(rsp_data1),
      .sram_ceb(sram_ceb), .sram_web(sram_web),
      .sram_a(sram_a), .sram_d(sram_d), .sram_m(sram_m),
      .sram_q(sram_q)
   );

   logic [W-1:0] mem [0:4095];
   always @(posedge CLK) begin
      if (sram_ceb) begin
         if (sram_web)
            mem[sram_a] <= (mem[sram_a] & ~sram_m) | (sram_d & sram_m);
         else
            sram_q <= mem[sram_a];
      end
   end

   typedef struct {
      logic [1:0]    v, w;
      logic [AW-1:0] a0, a1;
      logic [1:0]    rdy;
      logic          ceb, web;
      logic [AW-1:0] ea;
      logic [W-1:0]  esd, esm;
      logic [1:0]    rsp, cd;
      logic [W-1:0]  q0, q1;
   } vec_t;

   localparam logic [W-1:0] D  = {4{32'hDEADBEEF}};
   localparam logic [W-1:0] M  = {8{16'hF0F0}};
   localparam logic [W-1:0] X  = {32{4'h1}};
   localparam logic [W-1:0] Y  = {32{4'h2}};
   localparam logic [W-1:0] A5 = {16{8'hA5}};
   localparam logic [W-1:0] ON = {W{1'b1}};
   localparam logic [W-1:0] MK = {8{16'h00FF}};

   vec_t tbl [13];

   function automatic vec_t mk(
      logic [1:0] v, w, logic [AW-1:0] a0, a1,
      logic [1:0] rdy, logic ceb, web, logic [AW-1:0] ea,
      logic [W-1:0] esd, esm, logic [1:0] rsp, cd);
      vec_t r;
      r.v = v; r.w = w; r.a0 = a0; r.a1 = a1;
      r.rdy = rdy; r.ceb = ceb; r.web = web; r.ea = ea;
      r.esd = esd; r.esm = esm; r.rsp = rsp; r.cd = cd;
      r.q0 = X; r.q1 = Y;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] v, w,
                        input logic [AW-1:0] a0, a1,
                        input logic [W-1:0] d, m);
      req_valid = v; req_write = w;
      req_addr0 = a0; req_addr1 = a1;
      req_data0 = d; req_data1 = ~d;
      req_mask0 = m; req_mask1 = ~m;
   endtask

   task automatic idle();
      drive(2'b00, 2'b00, '0, '0, '0, '0);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic acc(input bit p, input logic w, input logic [AW-1:0] a,
                      input logic [W-1:0] d, input logic [W-1:0] m);
      if (p) drive(2'b10, {w, 1'b0}, '0, a, ~d, ~m);
      else   drive(2'b01, {1'b0, w}, a, '0, d, m);
      #4;
      chk("acc_ready", req_ready, p ? 2'b10 : 2'b01);
      step();
   endtask

   initial begin
      RSTN = 1'b0;
      drive(2'b11, 2'b00, 12'h010, 12'h020, D, M);
      repeat (3) @(posedge CLK);
      #5;
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_ceb", sram_ceb, 1'b0);
      chk("rst_a", sram_a, 0);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_rsp_data0", rsp_data0, 0);
      chk("rst_rsp_data1", rsp_data1, 0);
      step();
      RSTN = 1'b1;
      #4;
      chk("rel_first_grant", req_ready, 2'b01);
      step();
      #4;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      chk("rel_second_grant", req_ready, 2'b01);
`else
      chk("rel_second_grant", req_ready, 2'b10);
`endif
      step();
      acc(1'b0, 1'b1, 12'h005, A5, ON);
      acc(1'b0, 1'b1, 12'h010, X, ON);
      acc(1'b0, 1'b1, 12'h000, '0, ON);
      acc(1'b1, 1'b1, 12'h020, Y, ON);

`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      for (int i = 0; i < 6; i++)
         tbl[i] = mk(2'b11, 2'b00, 12'h010, 12'h020, 2'b01, 1, 0,
                     12'h010, 0, 0, (i >= 2) ? 2'b01 : 2'b00,
                     (i >= 2) ? 2'b01 : 2'b00);
      tbl[6]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b01);
      tbl[7]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b01);
      tbl[8]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b01);
      tbl[9]  = mk(2'b01, 2'b01, 12'h030, 0, 2'b01, 1, 1, 12'h030,
                   D, M, 2'b00, 2'b01);
      tbl[10] = mk(2'b11, 2'b10, 12'h040, 12'h050, 2'b01, 1, 0, 12'h040,
                   0, 0, 2'b00, 2'b01);
      tbl[11] = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      tbl[12] = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b00);
`else
      for (int i = 0; i < 6; i++)
         tbl[i] = mk(2'b11, 2'b00, 12'h010, 12'h020,
                     (i % 2) ? 2'b10 : 2'b01, 1, 0,
                     (i % 2) ? 12'h020 : 12'h010, 0, 0,
                     (i < 2) ? 2'b00 : ((i % 2) ? 2'b10 : 2'b01),
                     (i < 2) ? 2'b00 : ((i == 2) ? 2'b01 : 2'b11));
      tbl[6]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b01, 2'b11);
      tbl[7]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b10, 2'b11);
      tbl[8]  = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11);
      tbl[9]  = mk(2'b01, 2'b01, 12'h030, 0, 2'b01, 1, 1, 12'h030,
                   D, M, 2'b00, 2'b11);
      tbl[10] = mk(2'b11, 2'b10, 12'h040, 12'h050, 2'b10, 1, 1, 12'h050,
                   ~D, ~M, 2'b00, 2'b11);
      tbl[11] = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11);
      tbl[12] = mk(2'b00, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2'b11);
`endif

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].w, tbl[i].a0, tbl[i].a1, D, M);
         #4;
         chk($sformatf("t%0d_ready", i), req_ready, tbl[i].rdy);
         chk($sformatf("t%0d_ceb", i), sram_ceb, tbl[i].ceb);
         chk($sformatf("t%0d_web", i), sram_web, tbl[i].web);
         chk($sformatf("t%0d_a", i), sram_a, tbl[i].ea);
         chk($sformatf("t%0d_d", i), sram_d, tbl[i].esd);
         chk($sformatf("t%0d_m", i), sram_m, tbl[i].esm);
         chk($sformatf("t%0d_rsp_valid", i), rsp_valid, tbl[i].rsp);
         if (tbl[i].cd[0])
            chk($sformatf("t%0d_rsp_data0", i), rsp_data0, tbl[i].q0);
         if (tbl[i].cd[1])
            chk($sformatf("t%0d_rsp_data1", i), rsp_data1, tbl[i].q1);
         step();
      end

      acc(1'b1, 1'b0, 12'h005, '0, '0);
      idle();
      #4;
      chk("rd1_t1_valid", rsp_valid, 2'b00);
      step();
      #4;
      chk("rd1_t2_valid", rsp_valid, 2'b10);
      chk("rd1_t2_data", rsp_data1, A5);
      step();
      #4;
      chk("rd1_t3_valid", rsp_valid, 2'b00);
      chk("rd1_t3_hold", rsp_data1, A5);
      step();

      acc(1'b0, 1'b1, 12'h000, ON, MK);
      acc(1'b1, 1'b0, 12'h000, '0, '0);
      idle();
      #4;
      chk("wr_rd_t2_valid", rsp_valid, 2'b00);
      step();
      #4;
      chk("wr_rd_t3_valid", rsp_valid, 2'b10);
      chk("wr_rd_t3_data", rsp_data1, MK);
      step();

      acc(1'b0, 1'b1, 12'h060, D, ON);
      idle();
      for (int i = 0; i < 10; i++) begin
         #4;
         chk($sformatf("idle%0d_ceb", i), sram_ceb, 1'b0);
         step();
      end
      drive(2'b11, 2'b00, 12'h010, 12'h020, D, M);
      #4;
`ifdef SRAM_ARB_FIXED_PRIORITY_EN
      chk("idle_prio_kept", req_ready, 2'b01);
`else
      chk("idle_prio_kept", req_ready, 2'b10);
`endif
      step();
      idle();
      repeat (3) step();

      acc(1'b0, 1'b0, 12'h010, '0, '0);
      idle();
      #1;
      RSTN = 1'b0;
      #2;
      chk("mid_rst_data0", rsp_data0, 0);
      RSTN = 1'b1;
      #1;
      step();
      for (int i = 0; i < 4; i++) begin
         #4;
         chk($sformatf("mid_rst%0d_valid", i), rsp_valid, 2'b00);
         chk($sformatf("mid_rst%0d_data0", i), rsp_data0, 0);
         chk($sformatf("mid_rst%0d_data1", i), rsp_data1, 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
